// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC widths, mode encoding and request-arbiter defaults
package cordic_pkg;
  localparam int XY_W = 16;
  localparam int ANGLE_W = 32;
  localparam int CORDIC_NUM_REQ = 4;
  localparam int CORDIC_TAG_DEPTH = 32;
  typedef enum logic {CORDIC_ROTATE = 1'b0, CORDIC_VECTOR = 1'b1} cordic_mode_e;
endpackage

// File: rtl/cordic_tag_fifo.sv
// cordic_tag_fifo: requester-ID FIFO recording the issue order of in-flight CORDIC operations
module cordic_tag_fifo #(
  parameter int DEPTH = 32,
  parameter int TAG_W = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [TAG_W-1:0] tag,
  output logic [TAG_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [TAG_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= tag;
  end
endmodule

// File: rtl/cordic_req_arbiter.sv
// cordic_req_arbiter: round-robin sharing of one in-order CORDIC core among NUM_REQ requesters
module cordic_req_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = CORDIC_NUM_REQ,
  parameter int TAG_DEPTH = CORDIC_TAG_DEPTH,
  parameter int XY_W = cordic_pkg::XY_W,
  parameter int ANGLE_W = cordic_pkg::ANGLE_W,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(TAG_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_mode,
  input  logic [NUM_REQ*XY_W-1:0]  req_x,
  input  logic [NUM_REQ*XY_W-1:0]  req_y,
  input  logic [NUM_REQ*ANGLE_W-1:0] req_z,
  output logic                     core_in_valid,
  input  logic                     core_in_ready,
  output logic                     core_mode,
  output logic [XY_W-1:0]          core_x,
  output logic [XY_W-1:0]          core_y,
  output logic [ANGLE_W-1:0]       core_z,
  input  logic                     core_out_valid,
  output logic                     core_out_ready,
  input  logic [XY_W-1:0]          core_rx,
  input  logic [XY_W-1:0]          core_ry,
  input  logic [ANGLE_W-1:0]       core_rz,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [XY_W-1:0]          rsp_x,
  output logic [XY_W-1:0]          rsp_y,
  output logic [ANGLE_W-1:0]       rsp_z,
  output logic [CW-1:0]            outstanding,
  output logic                     err_orphan
);
  logic [IW-1:0] rr_ptr, gnt_idx, head;
  logic fifo_full, fifo_empty, issue, ret;
  cordic_mode_e gnt_mode;
  // Lowest offset from rr_ptr wins; iterating downward lets the nearest valid overwrite farther ones.
  always_comb begin
    gnt_idx = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[IW'((int'(rr_ptr) + k) % NUM_REQ)]) gnt_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
  end
  assign core_in_valid = |req_valid && !fifo_full;
  assign issue = core_in_valid && core_in_ready;
  assign req_ready = issue ? NUM_REQ'(1) << gnt_idx : '0;
  assign gnt_mode = cordic_mode_e'(req_mode[gnt_idx]);
  assign core_mode = gnt_mode;
  assign core_x = req_x[int'(gnt_idx)*XY_W +: XY_W];
  assign core_y = req_y[int'(gnt_idx)*XY_W +: XY_W];
  assign core_z = req_z[int'(gnt_idx)*ANGLE_W +: ANGLE_W];
  // With no tag the result is an orphan: swallow it so the core never stalls on it.
  assign core_out_ready = fifo_empty ? core_out_valid : rsp_ready[head];
  assign rsp_valid = (core_out_valid && !fifo_empty) ? NUM_REQ'(1) << head : '0;
  assign ret = core_out_valid && core_out_ready && !fifo_empty;
  assign rsp_x = core_rx;
  assign rsp_y = core_ry;
  assign rsp_z = core_rz;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (issue) rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (core_out_valid && fifo_empty) err_orphan <= 1'b1;
    end
  end
  cordic_tag_fifo #(.DEPTH(TAG_DEPTH), .TAG_W(IW)) u_tags (
    .clk(clk),
    .rst_n(rst_n),
    .push(issue),
    .pop(ret),
    .tag(gnt_idx),
    .head(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(outstanding)
  );
endmodule

// File: tb/tb_cordic_req_arbiter.sv
// tb_cordic_req_arbiter: randomized scoreboard bench with a behavioural core model and reference arbiter
module tb_cordic_req_arbiter;
  localparam int N = 4, DEPTH = 32, XW = 16, AW = 32, CW = 6;
  typedef struct { int ch; logic [XW-1:0] rx, ry; logic [AW-1:0] rz; } exp_t;
  typedef struct { logic [XW-1:0] rx, ry; logic [AW-1:0] rz; int due; } core_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
  logic [N*XW-1:0] req_x, req_y;
  logic [N*AW-1:0] req_z;
  logic core_in_valid, core_in_ready, core_mode, core_out_valid, core_out_ready, err_orphan;
  logic [XW-1:0] core_x, core_y, core_rx, core_ry, rsp_x, rsp_y;
  logic [AW-1:0] core_z, core_rz, rsp_z;
  logic [CW-1:0] outstanding;
  int n_cmp = 0, n_bad = 0, cyc = 0, lat = 16, p_req, p_cin, p_rsp;
  int m_cnt = 0, m_rr = 0, issue_cyc = 0, n_issue = 0, n_ret = 0;
  logic m_orphan = 1'b0, orphan_now = 1'b0, lat_chk = 1'b0;
  logic [N-1:0] vld = '0, om = '0;
  logic [XW-1:0] ox [N], oy [N];
  logic [AW-1:0] oz [N];
  exp_t sb [$];
  core_t pipe [$];
  int mtag [$];

  cordic_req_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_mode(core_mode),
    .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .core_rx(core_rx), .core_ry(core_ry), .core_rz(core_rz),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Stand-in CORDIC arithmetic: any fixed function of the operands proves correct routing.
  function automatic exp_t calc(int ch, logic [XW-1:0] x, logic [XW-1:0] y, logic [AW-1:0] z, logic m);
    exp_t e;
    e.ch = ch;
    e.rx = x + y;
    e.ry = x - y;
    e.rz = z + (m ? 32'h4000_0000 : 32'h1357_9bdf);
    return e;
  endfunction

  task automatic cycle();
    int g;
    logic found, exp_civ, pop, exp_cor;
    logic [N-1:0] exp_rdy;
    exp_t e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (!vld[i] && $urandom_range(99) < p_req) begin
        vld[i] = 1'b1;
        ox[i] = 16'($urandom);
        oy[i] = 16'($urandom);
        oz[i] = $urandom;
        om[i] = 1'($urandom);
      end
      req_valid[i] = vld[i];
      req_mode[i] = om[i];
      req_x[i*XW +: XW] = ox[i];
      req_y[i*XW +: XW] = oy[i];
      req_z[i*AW +: AW] = oz[i];
      rsp_ready[i] = $urandom_range(99) < p_rsp;
    end
    core_in_ready = $urandom_range(99) < p_cin;
    if (orphan_now) begin
      core_out_valid = 1'b1;
      core_rx = 16'($urandom);
      core_ry = 16'($urandom);
      core_rz = $urandom;
    end else if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      core_out_valid = 1'b1;
      core_rx = pipe[0].rx;
      core_ry = pipe[0].ry;
      core_rz = pipe[0].rz;
    end else core_out_valid = 1'b0;
    #2;
    chk("outstanding", 64'(outstanding), 64'(m_cnt));
    chk("err_orphan", 64'(err_orphan), 64'(m_orphan));
    found = 1'b0;
    g = 0;
    for (int k = 0; k < N; k++)
      if (!found && vld[(m_rr + k) % N]) begin
        g = (m_rr + k) % N;
        found = 1'b1;
      end
    exp_civ = found && m_cnt < DEPTH;
    exp_rdy = (exp_civ && core_in_ready) ? N'(1) << g : '0;
    chk("core_in_valid", 64'(core_in_valid), 64'(exp_civ));
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (exp_civ) begin
      chk("core_x", 64'(core_x), 64'(ox[g]));
      chk("core_y", 64'(core_y), 64'(oy[g]));
      chk("core_z", 64'(core_z), 64'(oz[g]));
      chk("core_mode", 64'(core_mode), 64'(om[g]));
    end
    if (m_cnt == 0) exp_cor = core_out_valid;
    else exp_cor = rsp_ready[mtag[0]];
    chk("core_out_ready", 64'(core_out_ready), 64'(exp_cor));
    if (core_in_valid && core_in_ready) begin
      e = calc(0, core_x, core_y, core_z, core_mode);
      pipe.push_back('{rx: e.rx, ry: e.ry, rz: e.rz, due: cyc + lat});
    end
    if (core_out_valid && core_out_ready && !orphan_now && pipe.size() > 0) void'(pipe.pop_front());
    pop = core_out_valid && m_cnt > 0 && exp_cor;
    if (core_out_valid && m_cnt == 0) m_orphan = 1'b1;
    if (pop) void'(mtag.pop_front());
    if (exp_civ && core_in_ready) begin
      mtag.push_back(g);
      sb.push_back(calc(g, ox[g], oy[g], oz[g], om[g]));
      issue_cyc = cyc;
      n_issue++;
      vld[g] = 1'b0;
      m_rr = (g + 1) % N;
    end
    m_cnt = mtag.size();
  endtask

  always @(negedge clk) begin : monitor
    logic [N-1:0] exp_rv;
    int ch;
    #1;
    if (rst_n) begin
      exp_rv = '0;
      if (sb.size() > 0 && core_out_valid) exp_rv = N'(1) << sb[0].ch;
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (|(rsp_valid & rsp_ready)) begin
        ch = 0;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) ch = i;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: channel %0d delivered with no result expected (cycle %0d)", ch, cyc);
        end else begin
          chk("rsp_channel", 64'(ch), 64'(sb[0].ch));
          chk("rsp_x", 64'(rsp_x), 64'(sb[0].rx));
          chk("rsp_y", 64'(rsp_y), 64'(sb[0].ry));
          chk("rsp_z", 64'(rsp_z), 64'(sb[0].rz));
          if (lat_chk) chk("latency", 64'(cyc - issue_cyc), 64'(lat));
          void'(sb.pop_front());
          n_ret++;
        end
      end
    end
  end

  task automatic drain();
    int t = 0;
    p_req = 0;
    p_cin = 100;
    p_rsp = 100;
    while ((|vld || m_cnt != 0 || pipe.size() != 0) && t < 400) begin
      cycle();
      t++;
    end
    n_cmp++;
    if (t >= 400) begin
      n_bad++;
      $display("FAIL drain: still busy after %0d cycles, outstanding model %0d", t, m_cnt);
    end
  endtask

  initial begin
    {req_valid, req_mode, req_x, req_y, req_z, rsp_ready} = '0;
    {core_in_ready, core_out_valid, core_rx, core_ry, core_rz} = '0;
    p_req = 0;
    p_cin = 100;
    p_rsp = 100;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("reset_core_out_ready", 64'(core_out_ready), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    vld[2] = 1'b1;
    om[2] = 1'b0;
    ox[2] = 16'sd19898;
    oy[2] = '0;
    oz[2] = 32'h2000_0000;
    lat_chk = 1'b1;
    n_ret = 0;
    repeat (24) cycle();
    lat_chk = 1'b0;
    chk("single_returns", 64'(n_ret), 64'(1));
    p_req = 100;
    repeat (60) cycle();
    drain();
    p_req = 100;
    p_rsp = 25;
    repeat (200) cycle();
    drain();
    n_issue = 0;
    p_req = 100;
    p_rsp = 0;
    repeat (40) cycle();
    chk("fill_issues", 64'(n_issue), 64'(DEPTH));
    chk("fill_outstanding", 64'(outstanding), 64'(DEPTH));
    chk("fill_core_in_valid", 64'(core_in_valid), 64'(0));
    p_rsp = 100;
    repeat (10) cycle();
    drain();
    for (int r = 0; r < 30; r++) begin
      if (r == 15) begin
        drain();
        lat = 2;
      end
      p_req = $urandom_range(100);
      p_cin = $urandom_range(100, 10);
      p_rsp = $urandom_range(100, 10);
      repeat (50) cycle();
    end
    drain();
    lat = 16;
    orphan_now = 1'b1;
    cycle();
    orphan_now = 1'b0;
    repeat (3) cycle();
    chk("orphan_sticky", 64'(err_orphan), 64'(1));
    p_req = 100;
    p_rsp = 0;
    for (int t = 0; t < 50 && m_cnt < 5; t++) cycle();
    p_cin = 0;
    repeat (20) cycle();
    chk("pre_reset_outstanding", 64'(outstanding), 64'(5));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outstanding", 64'(outstanding), 64'(0));
    chk("async_reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("async_reset_err_orphan", 64'(err_orphan), 64'(0));
    sb.delete();
    mtag.delete();
    pipe.delete();
    m_cnt = 0;
    m_rr = 0;
    m_orphan = 1'b0;
    vld = '0;
    req_valid = '0;
    core_out_valid = 1'b0;
    core_in_ready = 1'b0;
    rsp_ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    p_req = 100;
    p_cin = 100;
    p_rsp = 100;
    repeat (40) cycle();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
